// File: rtl/vco_pkg.sv
// ============================================================================
// Module      : vco_pkg
// Description : Constants and helpers shared by the VCO model and the
//               VCO phase decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vco_pkg;

   localparam int VCO_PHASE_WIDTH = 11;
   localparam int VCO_OSR         = 512;
   localparam int VCO_OUT_WIDTH   = 13;

   // Ceiling log2; returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int result;
      int remain;
      result = 0;
      remain = value - 1;
      while (remain > 0) begin
         result = result + 1;
         remain = remain >> 1;
      end
      return result;
   endfunction

endpackage : vco_pkg

`default_nettype wire

// File: rtl/vco_popcount.sv
// ============================================================================
// Module      : vco_popcount
// Description : Combinational population count of a phase-transition vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vco_popcount
   import vco_pkg::*;
#(
   parameter int PHASE_WIDTH = VCO_PHASE_WIDTH,
   parameter int CNT_WIDTH   = clog2(PHASE_WIDTH + 1)
)
(
   input  logic [PHASE_WIDTH-1:0] i_vec,
   output logic [CNT_WIDTH-1:0]   o_cnt
);

   always_comb begin
      o_cnt = '0;
      for (int i = 0; i < PHASE_WIDTH; i++) begin
         o_cnt = o_cnt + CNT_WIDTH'(i_vec[i]);
      end
   end

endmodule : vco_popcount

`default_nettype wire

// File: rtl/vco_phase_decoder.sv
// ============================================================================
// Module      : vco_phase_decoder
// Description : Samples the multi-phase VCO, counts phase transitions per
//               clock and integrates them over OSR samples into one code per
//               window, offered on a valid/ready port. Define VCO_DEC_SYNC_EN
//               to insert a 2-flop synchronizer on p_in.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vco_phase_decoder
   import vco_pkg::*;
#(
   parameter int PHASE_WIDTH = VCO_PHASE_WIDTH,
   parameter int OSR         = VCO_OSR,
   parameter int OUT_WIDTH   = VCO_OUT_WIDTH
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [PHASE_WIDTH-1:0] p_in,
   output logic [OUT_WIDTH-1:0]   dout,
   output logic                   dout_valid,
   input  logic                   dout_ready,
   output logic                   overflow,
   input  logic                   overflow_clr
);

   localparam int CNT_WIDTH = clog2(PHASE_WIDTH + 1);
   localparam int SC_WIDTH  = clog2(OSR);
   localparam logic [SC_WIDTH-1:0] c_sc_last = SC_WIDTH'(OSR - 1);

   generate
      if ((PHASE_WIDTH * OSR) >= (2 ** OUT_WIDTH)) begin : g_width_check
         $error("vco_phase_decoder: OUT_WIDTH too small for PHASE_WIDTH*OSR");
      end
      if ((OSR < 2) || ((OSR & (OSR - 1)) != 0)) begin : g_osr_check
         $error("vco_phase_decoder: OSR must be a power of two >= 2");
      end
   endgenerate

   logic [PHASE_WIDTH-1:0] r_p_s;
   logic [PHASE_WIDTH-1:0] r_p_prev;
   logic                   r_primed;
   logic [OUT_WIDTH-1:0]   r_acc;
   logic [SC_WIDTH-1:0]    r_sc;
   logic [OUT_WIDTH-1:0]   r_dout;
   logic                   r_dout_valid;
   logic                   r_overflow;

   logic [PHASE_WIDTH-1:0] w_diff;
   logic [CNT_WIDTH-1:0]   w_pop;
   logic [CNT_WIDTH-1:0]   w_cnt;
   logic [OUT_WIDTH-1:0]   w_sum;
   logic                   w_last;

`ifdef VCO_DEC_SYNC_EN
   logic [PHASE_WIDTH-1:0] r_sync1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_p_s   <= '0;
      end else begin
         r_sync1 <= p_in;
         r_p_s   <= r_sync1;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p_s <= '0;
      end else begin
         r_p_s <= p_in;
      end
   end
`endif

   // The previous-sample register runs regardless of enable so that a
   // re-enabled window starts from a valid reference.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p_prev <= '0;
         r_primed <= 1'b0;
      end else begin
         r_p_prev <= r_p_s;
         r_primed <= 1'b1;
      end
   end

   assign w_diff = r_p_s ^ r_p_prev;

   vco_popcount #(
      .PHASE_WIDTH (PHASE_WIDTH),
      .CNT_WIDTH   (CNT_WIDTH)
   ) u_popcount (
      .i_vec (w_diff),
      .o_cnt (w_pop)
   );

   assign w_cnt  = r_primed ? w_pop : '0;
   assign w_sum  = r_acc + OUT_WIDTH'(w_cnt);
   assign w_last = enable && (r_sc == c_sc_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_sc  <= '0;
      end else if (!enable || w_last) begin
         r_acc <= '0;
         r_sc  <= '0;
      end else begin
         r_acc <= w_sum;
         r_sc  <= r_sc + SC_WIDTH'(1);
      end
   end

   // A fresh result always loads; an unconsumed one being replaced flags overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_last) begin
            r_dout       <= w_sum;
            r_dout_valid <= 1'b1;
         end else if (r_dout_valid && dout_ready) begin
            r_dout_valid <= 1'b0;
         end

         if (w_last && r_dout_valid && !dout_ready) begin
            r_overflow <= 1'b1;
         end else if (overflow_clr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign overflow   = r_overflow;

endmodule : vco_phase_decoder

`default_nettype wire
